pc_fetch_stage: RTL and testbench

PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

---
 rtl/pc_fetch_stage.sv | 144 ++++++++++++++
 tb/tb_pc_fetch_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory request at a
// time, and delivers fetched words to decode through a registered slot backed by a one-entry hold buffer.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [15:0] redirect_count,
  output logic [1:0]  dbg_state
);

  // Handshakes: a memory request transfers on a cycle where imem_req_valid and
  // imem_req_ready are both 1; a response is a one-cycle imem_rsp_valid pulse with
  // no backpressure; decode takes if_* on any cycle where if_valid=1 and stall=0.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_KILL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [15:0] redirect_count_q, redirect_count_d;

  logic handshake;
  logic rsp_in_wait;
  logic slot_free;
  logic tgt_lsb_unused;

  assign imem_req_valid = (state_q == S_REQ) && !hold_valid_q;
  assign imem_addr      = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;
  assign redirect_count = redirect_count_q;
  assign dbg_state      = state_q;

  assign handshake      = imem_req_valid && imem_req_ready;
  assign rsp_in_wait    = (state_q == S_WAIT) && imem_rsp_valid;
  assign slot_free      = !if_valid_q || !stall;
  assign tgt_lsb_unused = ^branch_target[1:0];

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    if_valid_d       = if_valid_q;
    if_pc_d          = if_pc_q;
    if_instr_d       = if_instr_q;
    hold_valid_d     = hold_valid_q;
    hold_pc_d        = hold_pc_q;
    hold_instr_d     = hold_instr_q;
    redirect_count_d = redirect_count_q;

    if (branch_taken) begin
      pc_d             = {branch_target[31:2], 2'b00};
      if_valid_d       = 1'b0;
      hold_valid_d     = 1'b0;
      redirect_count_d = redirect_count_q + 16'd1;
      // A response landing in the redirect cycle is dropped here and leaves nothing
      // outstanding, so only a still-pending response needs KILL to swallow it.
      case (state_q)
        S_REQ:   state_d = handshake ? S_KILL : S_REQ;
        default: state_d = imem_rsp_valid ? S_REQ : S_KILL;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (handshake) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            pc_d    = pc_q + 32'd4;
            state_d = S_REQ;
          end
        end
        S_KILL: begin
          if (imem_rsp_valid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase

      if (rsp_in_wait) begin
        if (slot_free) begin
          if_valid_d = 1'b1;
          if_pc_d    = pc_q;
          if_instr_d = imem_rsp_data;
        end else begin
          hold_valid_d = 1'b1;
          hold_pc_d    = pc_q;
          hold_instr_d = imem_rsp_data;
        end
      end else if (slot_free && hold_valid_q) begin
        if_valid_d   = 1'b1;
        if_pc_d      = hold_pc_q;
        if_instr_d   = hold_instr_q;
        hold_valid_d = 1'b0;
      end else if (!stall) begin
        if_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_REQ;
      pc_q             <= RESET_PC;
      if_valid_q       <= 1'b0;
      if_pc_q          <= 32'h0;
      if_instr_q       <= 32'h0;
      hold_valid_q     <= 1'b0;
      hold_pc_q        <= 32'h0;
      hold_instr_q     <= 32'h0;
      redirect_count_q <= 16'h0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      if_valid_q       <= if_valid_d;
      if_pc_q          <= if_pc_d;
      if_instr_q       <= if_instr_d;
      hold_valid_q     <= hold_valid_d;
      hold_pc_q        <= hold_pc_d;
      hold_instr_q     <= hold_instr_d;
      redirect_count_q <= redirect_count_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: vector table for the basic stream and stall/hold path,
// directed redirect/reset sequences, a random run against a stream model, and counter wrap.
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic        imem_req_valid;
  logic [31:0] imem_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [15:0] redirect_count;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // memory model state
  logic        mem_pending;
  logic [31:0] mem_addr;
  int          mem_delay;
  int          mem_lat;
  logic        mem_rand;

  // stream reference model state
  logic [31:0] exp_pc;
  logic [15:0] exp_cnt;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic        stall;
    logic        req_v;
    logic [31:0] addr;
    logic        if_v;
    logic [31:0] if_pc;
  } vec_t;

  vec_t vecs[11];

  pc_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_addr      (imem_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .redirect_count (redirect_count),
    .dbg_state      (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst_n          = 1'b0;
    branch_taken   = 1'b0;
    branch_target  = 32'h0;
    stall          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    mem_pending    = 1'b0;
    mem_delay      = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Memory driver, called once per negedge after the other inputs are chosen.
  task automatic mem_step();
    logic pend_before;
    pend_before    = mem_pending;
    imem_req_ready = mem_rand ? ($urandom_range(0, 99) < 70) : 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (mem_pending) begin
      if (mem_delay == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
        mem_pending    = 1'b0;
      end else begin
        mem_delay--;
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      chk("one_outstanding", {31'h0, pend_before}, 32'h0);
      mem_pending = 1'b1;
      mem_addr    = imem_addr;
      mem_delay   = mem_rand ? $urandom_range(0, 2) : mem_lat;
    end
  endtask

  task automatic wait_if(input string name, input logic [31:0] pc);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (if_valid) begin
        found = 1'b1;
        chk({name, "_pc"}, if_pc, pc);
        chk({name, "_instr"}, if_instr, mem_word(pc));
      end else begin
        mem_step();
      end
    end
    if (!found) chk({name, "_timeout"}, 32'h0, 32'h1);
  endtask

  initial begin
    int consumed;
    logic must_hold;

    vecs[0]  = '{1'b0, 1'b1, 32'h0,  1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'h4,  1'b1, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h4,  1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
    vecs[5]  = '{1'b1, 1'b0, 32'h8,  1'b1, 32'h4};
    vecs[6]  = '{1'b1, 1'b0, 32'hC,  1'b1, 32'h4};
    vecs[7]  = '{1'b0, 1'b0, 32'hC,  1'b1, 32'h4};
    vecs[8]  = '{1'b0, 1'b1, 32'hC,  1'b1, 32'h8};
    vecs[9]  = '{1'b0, 1'b0, 32'hC,  1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'hC};

    mem_rand = 1'b0;
    mem_lat  = 0;

    // sequential stream, then stall with the hold buffer filling and draining
    reset_dut();
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_count", {16'h0, redirect_count}, 32'h0);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("vec%0d_req_valid", i), {31'h0, imem_req_valid}, {31'h0, vecs[i].req_v});
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("vec%0d_if_valid", i), {31'h0, if_valid}, {31'h0, vecs[i].if_v});
      if (vecs[i].if_v) begin
        chk($sformatf("vec%0d_if_pc", i), if_pc, vecs[i].if_pc);
        chk($sformatf("vec%0d_if_instr", i), if_instr, mem_word(vecs[i].if_pc));
      end
      stall = vecs[i].stall;
      mem_step();
    end

    // redirect while waiting: the outstanding response must be killed
    reset_dut();
    mem_lat = 1;
    mem_step();
    @(negedge clk);
    chk("wait_kill_req_valid", {31'h0, imem_req_valid}, 32'h0);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0100;
    mem_step();
    @(negedge clk);
    branch_taken = 1'b0;
    chk("wait_kill_count", {16'h0, redirect_count}, 32'h1);
    chk("wait_kill_addr", imem_addr, 32'h100);
    chk("wait_kill_if_valid", {31'h0, if_valid}, 32'h0);
    chk("kill_req_valid", {31'h0, imem_req_valid}, 32'h0);
    mem_step();
    wait_if("wait_kill_first", 32'h100);

    // redirect in the same cycle as a response, unaligned target
    reset_dut();
    mem_lat = 0;
    mem_step();
    @(negedge clk);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0103;
    mem_step();
    chk("same_cycle_rsp_present", {31'h0, imem_rsp_valid}, 32'h1);
    @(negedge clk);
    branch_taken = 1'b0;
    chk("same_cycle_if_valid", {31'h0, if_valid}, 32'h0);
    chk("same_cycle_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("same_cycle_addr", imem_addr, 32'h100);
    chk("same_cycle_count", {16'h0, redirect_count}, 32'h1);
    mem_step();
    wait_if("same_cycle_first", 32'h100);

    // reset in WAIT with a branch and responses around it
    reset_dut();
    chk("midrst_first_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("midrst_first_addr", imem_addr, 32'h0);
    imem_req_ready = 1'b1;
    @(negedge clk);
    chk("midrst_wait_req_valid", {31'h0, imem_req_valid}, 32'h0);
    imem_req_ready = 1'b0;
    rst_n          = 1'b0;
    branch_taken   = 1'b1;
    branch_target  = 32'h0000_0200;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n          = 1'b1;
    branch_taken   = 1'b0;
    imem_rsp_data  = 32'hBAD0_BAD0;
    chk("midrst_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_if_valid", {31'h0, if_valid}, 32'h0);
    chk("midrst_count", {16'h0, redirect_count}, 32'h0);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("late_rsp_if_valid", {31'h0, if_valid}, 32'h0);
    chk("late_rsp_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("late_rsp_addr", imem_addr, 32'h0);
    imem_req_ready = 1'b1;
    @(negedge clk);
    chk("after_rst_wait", {31'h0, imem_req_valid}, 32'h0);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = mem_word(32'h0);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("after_rst_if_valid", {31'h0, if_valid}, 32'h1);
    chk("after_rst_if_pc", if_pc, 32'h0);
    chk("after_rst_if_instr", if_instr, mem_word(32'h0));

    // random run: every word shown to decode must be the next word of the program stream
    reset_dut();
    mem_rand  = 1'b1;
    exp_pc    = 32'h0;
    exp_cnt   = 16'h0;
    consumed  = 0;
    must_hold = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (must_hold) chk("rand_hold_valid", {31'h0, if_valid}, 32'h1);
      chk("rand_count", {16'h0, redirect_count}, {16'h0, exp_cnt});
      if (if_valid) begin
        chk("rand_if_pc", if_pc, exp_pc);
        chk("rand_if_instr", if_instr, mem_word(exp_pc));
      end
      stall         = ($urandom_range(0, 99) < 30);
      branch_taken  = ($urandom_range(0, 99) < 6);
      branch_target = $urandom;
      must_hold     = 1'b0;
      if (branch_taken) begin
        exp_pc  = {branch_target[31:2], 2'b00};
        exp_cnt = exp_cnt + 16'd1;
        exp_q.delete();
      end else if (if_valid && !stall) begin
        exp_q.push_back(exp_pc);
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end else if (if_valid && stall) begin
        must_hold = 1'b1;
      end
      mem_step();
    end
    branch_taken = 1'b0;
    stall        = 1'b0;
    chk("rand_progress", {31'h0, (consumed >= 100)}, 32'h1);

    // redirect counter wrap
    reset_dut();
    mem_rand      = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_1236;
    repeat (65535) @(negedge clk);
    chk("wrap_count_max", {16'h0, redirect_count}, 32'h0000_FFFF);
    chk("wrap_addr", imem_addr, 32'h1234);
    chk("wrap_req_valid", {31'h0, imem_req_valid}, 32'h1);
    @(negedge clk);
    branch_taken = 1'b0;
    chk("wrap_count_zero", {16'h0, redirect_count}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
